// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers, one radix-2 step per cycle.
// The divider is built only when MDU_DIVIDE_EN is defined; otherwise DIV/DIVU are reserved.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg_lo;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef MDU_DIVIDE_EN
  logic               r_is_div;
  logic               r_neg_hi;
  logic               r_dz;
`endif

  logic               w_is_mul_op;
  logic               w_is_div_op;
  logic               w_signed;
  logic [WIDTH-1:0]   w_xa;
  logic [WIDTH-1:0]   w_ya;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
`ifdef MDU_DIVIDE_EN
  logic [WIDTH:0]     w_sh;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
`endif

  // Operand decode and magnitude extraction for the signed forms.
  always_comb begin
    w_is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIVIDE_EN
    w_is_div_op = (op == OP_DIV) || (op == OP_DIVU);
`else
    w_is_div_op = 1'b0;
`endif
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_xa     = (w_signed && x[WIDTH-1]) ? -x : x;
    w_ya     = (w_signed && y[WIDTH-1]) ? -y : y;
  end

  // Shift-add multiply: r_acc = {partial upper, multiplier shifting out}.
  always_comb begin
    w_addend = r_acc[0] ? r_opb : '0;
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_step   = {w_sum, r_acc[WIDTH-1:1]};
    w_prod   = r_neg_lo ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
`ifdef MDU_DIVIDE_EN
    // Restoring divide: r_acc = {remainder, dividend shifting into quotient}.
    w_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff = w_sh[WIDTH-1:0] - r_opb;
    if (w_sh >= {1'b0, r_opb})
      w_div_next = {w_diff, r_acc[WIDTH-2:0], 1'b1};
    else
      w_div_next = {w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    w_quo = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (r_is_div) begin
      w_step   = w_div_next;
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_neg_lo <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MDU_DIVIDE_EN
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_div_op && (y == '0)) begin
`ifdef MDU_DIVIDE_EN
              r_dz <= 1'b1;
`endif
              r_done <= 1'b1;
            end else if (w_is_mul_op || w_is_div_op) begin
`ifdef MDU_DIVIDE_EN
              r_dz     <= 1'b0;
              r_is_div <= w_is_div_op;
              r_neg_hi <= w_signed && x[WIDTH-1];
`endif
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= CW'(WIDTH);
              r_opb    <= w_is_div_op ? w_ya : w_xa;
              r_acc    <= {{WIDTH{1'b0}}, (w_is_div_op ? w_xa : w_ya)};
              r_neg_lo <= w_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
            end else if (op == OP_MTHI) begin
`ifdef MDU_DIVIDE_EN
              r_dz <= 1'b0;
`endif
              r_hi <= x;
            end else if (op == OP_MTLO) begin
`ifdef MDU_DIVIDE_EN
              r_dz <= 1'b0;
`endif
              r_lo <= x;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign o_state = r_state;
`ifdef MDU_DIVIDE_EN
  assign div_zero = r_dz;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: randomized and directed operations against an arithmetic model.
// Divide scenarios follow MDU_DIVIDE_EN the same way the design does.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [1:0]    o_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  logic [2*W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows dividend.
  function automatic logic [2*W-1:0] ref_result(input logic [2:0] f_op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint     sa, sb, sq, sr;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (f_op)
      3'b000: res = 64'(sa * sb);
      3'b001: res = ua * ub;
      3'b010: begin
        sq = sa / sb;
        sr = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      3'b011: res = {32'(ua % ub), 32'(ua / ub)};
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; x = a; y = b;
    @(negedge clk);
    start = 1'b0; x = $urandom; y = $urandom;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_op(o, a, b);
  endtask

  // Called one negedge after an accepted iterative op; counts remaining busy cycles.
  task automatic check_iter(input string name, input int exp_cycles);
    int cyc;
    logic [2*W-1:0] e;
    e = exp_q.pop_front();
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_total++;
    if (cyc !== exp_cycles) $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cyc, exp_cycles);
    else n_pass++;
    n_total++;
    if (done !== 1'b1) $display("FAIL %s_done: got %b expected 1", name, done);
    else n_pass++;
    n_total++;
    if ({hi, lo} !== e) $display("FAIL %s_result: got %h_%h expected %h_%h", name, hi, lo, e[63:32], e[31:0]);
    else n_pass++;
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, div_zero, hi, lo} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h expected all zero", busy, done, div_zero, hi, lo);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [2:0] o;
    logic [W-1:0] a, b;
    exp_q.push_back(ref_result(3'b000, 32'hFFFFFFFD, 32'd7));
    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    check_iter("mult_neg3x7", W + 1);
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b expected 0", done);
    else n_pass++;
    exp_q.push_back(ref_result(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF));
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_iter("multu_max", W + 1);
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 0) ? 32'h80000000 : $urandom;
      exp_q.push_back(ref_result(o, a, b));
      issue(o, a, b);
      check_iter("mult_rand", W + 1);
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    exp_q.push_back(ref_result(3'b001, a, b));
    issue(3'b001, a, b);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'b100; x = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (hi !== m_hi || busy !== 1'b1)
      $display("FAIL busy_ignore_mthi: got hi=%h busy=%b expected hi=%h busy=1", hi, busy, m_hi);
    else n_pass++;
    check_iter("busy_ignore_multu", W + 1 - 4);
  endtask

`ifdef MDU_DIVIDE_EN
  task automatic test_div();
    logic [2:0] o;
    logic [W-1:0] a, b;
    exp_q.push_back(ref_result(3'b010, 32'hFFFFFFF9, 32'd2));
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    check_iter("div_neg7_2", W + 1);
    exp_q.push_back(ref_result(3'b011, 32'd7, 32'd2));
    issue(3'b011, 32'd7, 32'd2);
    check_iter("divu_7_2", W + 1);
    exp_q.push_back({32'h0, 32'h80000000});
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    check_iter("div_minneg", W + 1);
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(2, 3));
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 1) b = -b;
      if (b == '0) b = 32'd1;
      exp_q.push_back(ref_result(o, a, b));
      issue(o, a, b);
      check_iter("div_rand", W + 1);
    end
  endtask

  task automatic test_div_zero();
    issue(3'b011, 32'd5, 32'd0);
    n_total++;
    if (div_zero !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL divzero_flags: got dz=%b done=%b busy=%b expected 1 1 0", div_zero, done, busy);
    else n_pass++;
    n_total++;
    if (hi !== m_hi || lo !== m_lo)
      $display("FAIL divzero_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || div_zero !== 1'b1)
      $display("FAIL divzero_hold: got done=%b dz=%b expected 0 1", done, div_zero);
    else n_pass++;
    issue(3'b110, 32'h11111111, 32'h0);
    n_total++;
    if (div_zero !== 1'b1 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo)
      $display("FAIL reserved_keeps_dz: got dz=%b busy=%b hi=%h lo=%h expected 1 0 %h %h", div_zero, busy, hi, lo, m_hi, m_lo);
    else n_pass++;
    issue(3'b101, 32'h5555AAAA, 32'h0);
    m_lo = 32'h5555AAAA;
    n_total++;
    if (div_zero !== 1'b0 || lo !== m_lo)
      $display("FAIL mtlo_clears_dz: got dz=%b lo=%h expected 0 %h", div_zero, lo, m_lo);
    else n_pass++;
  endtask
`else
  task automatic test_div_disabled();
    logic [2:0] o;
    for (int i = 0; i < 4; i++) begin
      o = (i < 2) ? 3'b010 : 3'b011;
      issue(o, $urandom, (i % 2 == 0) ? 32'd0 : 32'd3);
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi !== m_hi || lo !== m_lo)
        $display("FAIL div_disabled: got busy=%b done=%b dz=%b hi=%h lo=%h expected 0 0 0 %h %h", busy, done, div_zero, hi, lo, m_hi, m_lo);
      else n_pass++;
    end
    issue(3'b111, 32'h11111111, 32'h0);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo)
      $display("FAIL reserved_ignored: got busy=%b done=%b hi=%h lo=%h expected 0 0 %h %h", busy, done, hi, lo, m_hi, m_lo);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [W-1:0] a, b;
    issue(3'b000, $urandom | 32'h1, $urandom | 32'h10000);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0)
      $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    else n_pass++;
    a = $urandom; b = $urandom;
    exp_q.push_back(ref_result(3'b000, a, b));
    start_op(3'b000, a, b);
    check_iter("after_reset_mult", W + 1);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 3'b100; x = 32'h12345678;
    @(negedge clk);
    n_total++;
    if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mthi: got hi=%h busy=%b done=%b expected 12345678 0 0", hi, busy, done);
    else n_pass++;
    op = 3'b101; x = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected 12345678 9abcdef0 0 0", hi, lo, busy, done);
    else n_pass++;
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    exp_q.push_back(ref_result(3'b000, a, b));
    issue(3'b000, a, b);
    check_iter("b2b_first", W + 1);
    a = $urandom; b = $urandom;
    exp_q.push_back(ref_result(3'b001, a, b));
    start_op(3'b001, a, b);
    check_iter("b2b_second", W + 1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_busy_ignore();
`ifdef MDU_DIVIDE_EN
    test_div();
    test_div_zero();
`else
    test_div_disabled();
`endif
    test_reset_mid();
    test_mthi_mtlo();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
